// File: rtl/jt7759_adpcm_dec.sv
// uPD7759 ADPCM nibble decoder: step ROM, saturating accumulator, 3-clk pipeline.
// Define JT7759_SMOOTH_EN to add a cen_ctl-rate output smoothing filter.
module jt7759_adpcm_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen_dec,
  input  logic       cen_ctl,
  input  logic       dec_rst,
  input  logic [3:0] dec_din,
  output logic [8:0] sound,
  output logic       snd_ok
);

  // Step magnitudes for nibble indexes 0..7; bit3 of the nibble negates.
  localparam logic [8:0] MAG [16][8] = '{
    '{9'd0, 9'd0,  9'd1,  9'd2,  9'd3,  9'd5,   9'd7,   9'd10 },
    '{9'd0, 9'd1,  9'd2,  9'd3,  9'd4,  9'd6,   9'd8,   9'd13 },
    '{9'd0, 9'd1,  9'd2,  9'd4,  9'd5,  9'd7,   9'd10,  9'd15 },
    '{9'd0, 9'd1,  9'd3,  9'd4,  9'd6,  9'd9,   9'd13,  9'd19 },
    '{9'd0, 9'd2,  9'd3,  9'd5,  9'd8,  9'd11,  9'd15,  9'd23 },
    '{9'd0, 9'd2,  9'd4,  9'd7,  9'd10, 9'd14,  9'd19,  9'd29 },
    '{9'd0, 9'd3,  9'd5,  9'd8,  9'd12, 9'd16,  9'd22,  9'd33 },
    '{9'd1, 9'd4,  9'd7,  9'd10, 9'd15, 9'd20,  9'd29,  9'd43 },
    '{9'd1, 9'd4,  9'd8,  9'd13, 9'd18, 9'd25,  9'd35,  9'd53 },
    '{9'd1, 9'd6,  9'd10, 9'd16, 9'd22, 9'd31,  9'd43,  9'd64 },
    '{9'd2, 9'd7,  9'd12, 9'd19, 9'd27, 9'd37,  9'd51,  9'd76 },
    '{9'd2, 9'd9,  9'd16, 9'd24, 9'd34, 9'd46,  9'd64,  9'd96 },
    '{9'd3, 9'd11, 9'd19, 9'd29, 9'd41, 9'd57,  9'd79,  9'd117},
    '{9'd4, 9'd14, 9'd25, 9'd37, 9'd54, 9'd74,  9'd102, 9'd152},
    '{9'd6, 9'd18, 9'd32, 9'd48, 9'd67, 9'd94,  9'd130, 9'd195},
    '{9'd8, 9'd24, 9'd42, 9'd63, 9'd88, 9'd123, 9'd171, 9'd256}
  };

  logic [3:0]        adpcm_st;
  logic signed [7:0] acc;
  logic signed [7:0] step;
  logic [3:0]        nib_l;
  logic              v1;

  logic [8:0]        mag;
  logic signed [7:0] step_nxt;
  logic signed [8:0] acc_sum;
  logic signed [7:0] acc_nxt;
  logic signed [4:0] adj;
  logic signed [4:0] st_sum;
  logic [3:0]        st_nxt;

  // Entries wider than 8 bits clip to the signed 8-bit range.
  always_comb begin
    mag = MAG[adpcm_st][dec_din[2:0]];
    step_nxt = '0;
    if (dec_din[3])
      step_nxt = (mag >= 9'd128) ? -8'sd128 : -$signed(mag[7:0]);
    else
      step_nxt = (mag >= 9'd128) ? 8'sd127 : $signed(mag[7:0]);
  end

  always_comb begin
    acc_sum = {acc[7], acc} + {step[7], step};
    acc_nxt = acc_sum[7:0];
    if (acc_sum[8] != acc_sum[7])
      acc_nxt = acc_sum[8] ? -8'sd128 : 8'sd127;
  end

  always_comb begin
    adj = 5'sd0;
    unique case (nib_l[2:0])
      3'd0, 3'd1: adj = -5'sd1;
      3'd2, 3'd3: adj = 5'sd0;
      3'd4:       adj = 5'sd1;
      3'd5, 3'd6: adj = 5'sd2;
      default:    adj = 5'sd3;
    endcase
    st_sum = $signed({1'b0, adpcm_st}) + adj;
    st_nxt = st_sum[3:0];
    // bit4 means below 0 for a negative adjust, above 15 otherwise
    if (st_sum[4])
      st_nxt = adj[4] ? 4'd0 : 4'd15;
  end

`ifdef JT7759_SMOOTH_EN
  logic signed [8:0] filt;
  logic signed [9:0] fsum;

  assign fsum  = {filt[8], filt} + {acc[7], acc, 1'b0};
  assign sound = filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      adpcm_st <= '0;
      acc      <= '0;
      step     <= '0;
      nib_l    <= '0;
      v1       <= 1'b0;
      filt     <= '0;
      snd_ok   <= 1'b0;
    end else if (dec_rst) begin
      adpcm_st <= '0;
      acc      <= '0;
      v1       <= 1'b0;
      filt     <= '0;
      snd_ok   <= 1'b0;
    end else begin
      v1     <= cen_dec;
      snd_ok <= cen_ctl;
      if (cen_dec) begin
        nib_l <= dec_din;
        step  <= step_nxt;
      end
      if (v1) begin
        acc      <= acc_nxt;
        adpcm_st <= st_nxt;
      end
      if (cen_ctl)
        filt <= fsum[9:1];
    end
  end
`else
  logic v2;
  logic ctl_unused;

  assign ctl_unused = cen_ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      adpcm_st <= '0;
      acc      <= '0;
      step     <= '0;
      nib_l    <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      sound    <= '0;
      snd_ok   <= 1'b0;
    end else if (dec_rst) begin
      adpcm_st <= '0;
      acc      <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      sound    <= '0;
      snd_ok   <= 1'b0;
    end else begin
      v1     <= cen_dec;
      v2     <= v1;
      snd_ok <= v2;
      if (cen_dec) begin
        nib_l <= dec_din;
        step  <= step_nxt;
      end
      if (v1) begin
        acc      <= acc_nxt;
        adpcm_st <= st_nxt;
      end
      if (v2)
        sound <= {acc, 1'b0};
    end
  end
`endif

endmodule

// File: tb/tb_jt7759_adpcm_dec.sv
// Directed bench for jt7759_adpcm_dec; expected values worked out by hand
// from the uPD7759 step/adjust tables.
module tb_jt7759_adpcm_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen_dec;
  logic       cen_ctl;
  logic       dec_rst;
  logic [3:0] dec_din;
  logic [8:0] sound;
  logic       snd_ok;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  jt7759_adpcm_dec dut (
    .clk     (clk),
    .rst     (rst),
    .cen_dec (cen_dec),
    .cen_ctl (cen_ctl),
    .dec_rst (dec_rst),
    .dec_din (dec_din),
    .sound   (sound),
    .snd_ok  (snd_ok)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int snd();
    return int'($signed(sound));
  endfunction

  function automatic int accv();
    return int'(dut.acc);
  endfunction

  function automatic int stv();
    return int'(dut.adpcm_st);
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One nibble strobe, then wait until the sample is on the output.
  task automatic dec(input logic [3:0] n);
    cen_dec = 1'b1;
    dec_din = n;
    @(negedge clk);
    cen_dec = 1'b0;
    cyc(2);
  endtask

  task automatic clear();
    dec_rst = 1'b1;
    @(negedge clk);
    dec_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dec_rst = 1'b1;
    cen_dec = 1'b0;
    cen_ctl = 1'b0;
    dec_din = 4'd0;
    cyc(3);
    chk("rst_sound", snd(), 0);
    chk("rst_ok", int'(snd_ok), 0);
    chk("rst_acc", accv(), 0);
    chk("rst_st", stv(), 0);
    rst = 1'b0;
    cyc(1);
    dec_rst = 1'b0;
    cyc(1);

`ifndef JT7759_SMOOTH_EN
    cen_dec = 1'b1;
    dec_din = 4'd7;
    @(negedge clk);
    cen_dec = 1'b0;
    cyc(1);
    chk("lat_ok_early", int'(snd_ok), 0);
    chk("lat_snd_early", snd(), 0);
    cyc(1);
    chk("n7_sound", snd(), 20);
    chk("n7_ok", int'(snd_ok), 1);
    chk("n7_st", stv(), 3);
    chk("n7_acc", accv(), 10);
    cyc(1);
    chk("n7_ok_pulse", int'(snd_ok), 0);
    chk("n7_hold", snd(), 20);

    clear();
    dec(4'd9);
    chk("n9_sound", snd(), 0);
    chk("n9_ok", int'(snd_ok), 1);
    chk("n9_st", stv(), 0);

    dec(4'd15);
    chk("neg1_sound", snd(), -20);
    chk("neg1_st", stv(), 3);
    dec(4'd15);
    chk("neg2_sound", snd(), -58);
    chk("neg2_st", stv(), 6);

    clear();
    for (int i = 0; i < 40; i++) dec(4'd7);
    chk("sat_st", stv(), 15);
    chk("sat_acc", accv(), 127);
    chk("sat_sound", snd(), 254);
    cyc(25);
    chk("idle_sound", snd(), 254);
    chk("idle_acc", accv(), 127);
    chk("idle_st", stv(), 15);
    chk("idle_ok", int'(snd_ok), 0);

    dec_rst = 1'b1;
    cen_dec = 1'b1;
    dec_din = 4'd7;
    @(negedge clk);
    dec_rst = 1'b0;
    cen_dec = 1'b0;
    chk("both_acc", accv(), 0);
    chk("both_sound", snd(), 0);
    for (int i = 0; i < 4; i++) begin
      chk("both_no_ok", int'(snd_ok), 0);
      @(negedge clk);
    end
    chk("both_acc_after", accv(), 0);
    chk("both_st_after", stv(), 0);

    dec(4'd7);
    chk("pre_drop_sound", snd(), 20);
    cen_dec = 1'b1;
    dec_din = 4'd7;
    @(negedge clk);
    cen_dec = 1'b0;
    dec_rst = 1'b1;
    @(negedge clk);
    dec_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drop_no_ok", int'(snd_ok), 0);
      @(negedge clk);
    end
    chk("drop_sound", snd(), 0);
    chk("drop_acc", accv(), 0);

    dec(4'd7);
    chk("pre_rst_sound", snd(), 20);
    cen_dec = 1'b1;
    dec_din = 4'd7;
    @(negedge clk);
    cen_dec = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_drop_no_ok", int'(snd_ok), 0);
      @(negedge clk);
    end
    chk("rst_drop_sound", snd(), 0);
    chk("rst_drop_acc", accv(), 0);
`else
    dec(4'd7);
    dec(4'd0);
    dec(4'd6);
    chk("sm_acc", accv(), 20);
    chk("sm_st", stv(), 4);
    chk("sm_sound0", snd(), 0);
    chk("sm_ok0", int'(snd_ok), 0);
    cen_ctl = 1'b1;
    @(negedge clk);
    cen_ctl = 1'b0;
    chk("sm_sound1", snd(), 20);
    chk("sm_ok1", int'(snd_ok), 1);
    cyc(2);
    chk("sm_ok_pulse", int'(snd_ok), 0);
    cen_ctl = 1'b1;
    @(negedge clk);
    cen_ctl = 1'b0;
    chk("sm_sound2", snd(), 30);
    chk("sm_ok2", int'(snd_ok), 1);
    clear();
    chk("sm_clr_sound", snd(), 0);
    chk("sm_clr_acc", accv(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
